// File: rtl/alu_dec_pkg.sv
// Shared types for the ALU/decoder core: opcodes, FSM states and the default operand width.
package alu_dec_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_DEC = 3'd4,
        OP_B2G = 3'd5,
        OP_G2B = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_dec_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per enabled cycle, WIDTH steps.
module alu_dec_mul
    import alu_dec_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic               busy_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // done marks the edge that performs the final step; product already includes it.
    assign done    = busy_reg & ena & (cnt_reg == CW'(WIDTH - 1));
    assign product = acc_next;
    assign busy    = busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
        end else if (ena) begin
            if (start) begin
                busy_reg   <= 1'b1;
                cnt_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, a};
                mplier_reg <= b;
                acc_reg    <= '0;
            end else if (busy_reg) begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CW'(1);
                if (done) begin
                    busy_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_dec_core.sv
// Valid/ready ALU with decoder and Gray-code ops; single-cycle ops complete in one edge, MUL iterates.
module alu_dec_core
    import alu_dec_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_zero,
    output logic                 flag_carry,
    output logic                 flag_ovf,
    output logic                 busy
);

    localparam int IW = $clog2(2 * WIDTH);
    localparam logic [2*WIDTH-1:0] DEC_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_e             state_reg, state_next;
    logic [2*WIDTH-1:0] result_reg;
    logic               zero_reg, carry_reg, ovf_reg;

    logic               xfer_in, xfer_out, is_mul, mul_start, mul_done, mul_busy;
    logic [2*WIDTH-1:0] mul_product;
    logic [2*WIDTH-1:0] alu_result;
    logic               alu_carry, alu_ovf;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [WIDTH-1:0]   g2b;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    // Gray-to-binary: each bit is the XOR of itself and every bit above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign g2b[gi] = ^a[WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                alu_result = {{WIDTH{1'b0}}, sum_ext[WIDTH-1:0]};
                alu_carry  = sum_ext[WIDTH];
                alu_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = {{WIDTH{1'b0}}, diff_ext[WIDTH-1:0]};
                alu_carry  = diff_ext[WIDTH];
                alu_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_result = {{WIDTH{1'b0}}, a & b};
            OP_XOR:  alu_result = {{WIDTH{1'b0}}, a ^ b};
            OP_DEC:  alu_result = DEC_ONE << a[IW-1:0];
            OP_B2G:  alu_result = {{WIDTH{1'b0}}, a ^ (a >> 1)};
            OP_G2B:  alu_result = {{WIDTH{1'b0}}, g2b};
            default: ;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_IDLE: in_ready = ena;
            ST_DONE: in_ready = ena & out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = (state_reg == ST_DONE);
    assign xfer_in   = ena & in_valid & in_ready;
    assign xfer_out  = ena & out_valid & out_ready;
    assign is_mul    = (op_e'(op) == OP_MUL);
    assign mul_start = xfer_in & is_mul;
    assign busy      = mul_busy;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (xfer_in) state_next = is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_next = ST_DONE;
            ST_DONE: begin
                if (xfer_in)       state_next = is_mul ? ST_MUL : ST_DONE;
                else if (xfer_out) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (ena) begin
            state_reg <= state_next;
            if (xfer_in && !is_mul) begin
                result_reg <= alu_result;
                zero_reg   <= (alu_result == '0);
                carry_reg  <= alu_carry;
                ovf_reg    <= alu_ovf;
            end else if (mul_done) begin
                result_reg <= mul_product;
                zero_reg   <= (mul_product == '0);
                carry_reg  <= 1'b0;
                ovf_reg    <= 1'b0;
            end
        end
    end

    assign result     = result_reg;
    assign flag_zero  = zero_reg;
    assign flag_carry = carry_reg;
    assign flag_ovf   = ovf_reg;

    alu_dec_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_alu_dec_core.sv
// Directed vector bench for alu_dec_core at WIDTH=4, plus backpressure, enable and reset sequences.
module tb_alu_dec_core;

    logic       clk = 1'b0;
    logic       rst_n, ena, in_valid, out_ready;
    logic       in_ready, out_valid, flag_zero, flag_carry, flag_ovf, busy;
    logic [2:0] op;
    logic [3:0] a, b;
    logic [7:0] result;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    alu_dec_core #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits on negedges for out_valid; returns edges waited and busy cycles seen.
    task automatic wait_result(input string name, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (out_valid) return;
        end
        check({name, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic launch(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y, input logic ordy);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = ~o; a = ~x; b = ~y;
    endtask

    initial begin
        int lat, bc, seen;
        vecs[0]  = '{3'd0, 4'h7, 4'h1, 8'h08, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'd0, 4'h7, 4'h9, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd1, 4'h3, 4'h5, 8'h0E, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'd1, 4'h8, 4'h1, 8'h07, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'd1, 4'h5, 4'h5, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'd2, 4'hC, 4'hA, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 4'hF, 4'h3, 8'h0C, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd4, 4'h5, 4'h0, 8'h20, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 4'hD, 4'h0, 8'h20, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd5, 4'hB, 4'h0, 8'h0E, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 4'hE, 4'h0, 8'h0B, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'd7, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd7, 4'h0, 4'h9, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{3'd4, 4'h7, 4'h0, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'd0, 4'hF, 4'h1, 8'h00, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; a = 4'h0; b = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            wait_result("vec", lat, bc);
            $display("[TB] vec %0d op=%0d a=0x%h b=0x%h -> result=0x%h z=%b c=%b v=%b lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, result, flag_zero, flag_carry, flag_ovf, lat);
            check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("vec%0d_zero", i), 32'(flag_zero), 32'(vecs[i].z));
            check($sformatf("vec%0d_carry", i), 32'(flag_carry), 32'(vecs[i].c));
            check($sformatf("vec%0d_ovf", i), 32'(flag_ovf), 32'(vecs[i].v));
            check($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].op == 3'd7) ? 32'd5 : 32'd1);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), (vecs[i].op == 3'd7) ? 32'd4 : 32'd0);
            @(posedge clk);
        end

        // Backpressure in DONE, then simultaneous output and input transfer.
        launch(3'd0, 4'h7, 4'h1, 1'b0);
        wait_result("bp", lat, bc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_result", k), 32'(result), 32'h08);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold%0d_out_valid", k), 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd3; a = 4'hF; b = 4'h3;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        $display("[TB] back-to-back XOR -> result=0x%h out_valid=%b", result, out_valid);
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_result", 32'(result), 32'h0C);
        @(posedge clk);

        // Enable dropped for 3 cycles mid-MUL: the count resumes afterwards.
        launch(3'd7, 4'h3, 4'h5, 1'b1);
        repeat (2) @(negedge clk);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ena_off%0d_busy", k), 32'(busy), 32'd1);
            check($sformatf("ena_off%0d_in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("ena_off%0d_out_valid", k), 32'(out_valid), 32'd0);
        end
        ena = 1'b1;
        wait_result("ena", lat, bc);
        $display("[TB] MUL with ena gap -> result=0x%h lat=%0d", result, lat);
        check("ena_mul_latency", 32'(lat + 5), 32'd8);
        check("ena_mul_result", 32'(result), 32'h0F);
        @(posedge clk);

        // Reset during MUL cycle 2 discards the pending product.
        launch(3'd7, 4'hF, 4'hF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", 32'(result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        $display("[TB] reset mid-MUL -> activity after release=%0d in_ready=%b", seen, in_ready);
        check("mid_rst_no_result", 32'(seen), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);

        launch(3'd1, 4'h3, 4'h5, 1'b1);
        wait_result("post", lat, bc);
        $display("[TB] SUB after reset -> result=0x%h", result);
        check("post_rst_result", 32'(result), 32'h0E);
        check("post_rst_latency", 32'(lat), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_dec_core.md
ALU_DEC_CORE -- requirements
Module: alu_dec_core

Interface
REQ-001 Parameter WIDTH, default 4, operand width; legal values 2, 4, 8 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  block enable; low freezes all state.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  core accepts a request this cycle.
REQ-007 op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 DEC, 5 B2G, 6 G2B, 7 MUL.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  2*WIDTH  registered result.
REQ-012 flag_zero, flag_carry, flag_ovf  output  1 each  registered status flags.
REQ-013 busy  output  1  high while a MUL is iterating.

Function
REQ-014 Input transfer occurs at a rising edge with ena & in_valid & in_ready; output transfer occurs at a rising edge with ena & out_valid & out_ready.
REQ-015 FSM states: IDLE, MUL, DONE.
REQ-016 IDLE: in_ready=ena; out_valid=0; on transfer of op 0-6, register result/flags, go to DONE (latency 1); on op 7, go to MUL.
REQ-017 MUL: shift-add, one partial-product bit per cycle, exactly WIDTH cycles, then DONE; busy=1, in_ready=0.
REQ-018 DONE: out_valid=1; result and flags stable until output transfer; in_ready = ena & out_ready.
REQ-019 DONE with output transfer and no input transfer at the same edge: go to IDLE.
REQ-020 DONE with output and input transfer at the same edge: accept the new op per REQ-016 (back-to-back, no bubble).
REQ-021 ADD/SUB: result = low WIDTH bits of a+b / a-b, zero-extended; flag_carry = carry-out (ADD) or borrow (SUB); flag_ovf = two's-complement signed overflow.
REQ-022 AND/XOR: bitwise, zero-extended; flag_carry=flag_ovf=0.
REQ-023 DEC: result = one-hot, bit index a[log2(2*WIDTH)-1:0] set; higher bits of a ignored.
REQ-024 B2G: a ^ (a>>1); G2B: prefix XOR from MSB down; both zero-extended.
REQ-025 MUL: full unsigned 2*WIDTH-bit product; flag_carry=flag_ovf=0.
REQ-026 flag_zero = (result == 0), for every op.
REQ-027 ena low: no transfers, FSM and all registers hold, in_ready=0, out_valid holds its value; a MUL resumes its count when ena returns.
REQ-028 Inputs a, b, op are sampled only at input transfer; later changes do not affect an in-flight op.

Reset
REQ-029 rst_n low, asynchronously: state IDLE, result=0, all flags=0, out_valid=0, busy=0, MUL counter and partial product cleared.
REQ-030 Reset mid-MUL or in DONE discards the pending result; no out_valid after release until a new op completes.
REQ-031 After release, in_ready = ena.

Structure
REQ-032 Shared package alu_dec_pkg holds the opcode enum, FSM state enum and default WIDTH constant.
REQ-033 Iterative multiplier is sub-module alu_dec_mul (start, operands, busy, done, product); all other ops combinational inside alu_dec_core.

Verification (WIDTH=4)
REQ-034 ADD a=7 b=1 -> result 0x08, carry 0, ovf 1, zero 0; ADD a=7 b=9 -> result 0x00, zero 1, carry 1, ovf 0.
REQ-035 SUB a=3 b=5 -> result 0x0E, carry(borrow) 1, ovf 0; out_valid exactly 1 cycle after transfer.
REQ-036 MUL a=15 b=15 -> result 0xE1, busy high 4 cycles, out_valid first high 5 cycles after transfer.
REQ-037 B2G a=0xB -> 0x0E; G2B a=0xE -> 0x0B; DEC a=0x5 -> 0x20; DEC a=0xD -> 0x20.
REQ-038 Hold out_ready=0 3 cycles in DONE -> result stable, in_ready 0; then out_ready=1 with in_valid=1 (XOR 0xF,0x3) -> both transfers at one edge, next result 0x0C.
REQ-039 rst_n pulsed low during MUL cycle 2 -> out_valid/busy 0 immediately, no result emitted after release, in_ready=1 with ena=1.
